// File: rtl/conv_seq_pkg.sv
// -----------------------------------------------------------------------------
// conv_seq_pkg
// Shared definitions for the conversion sequencer: FSM state encoding, default
// block/timeout constants and a width helper used to size the watchdog timer.
// -----------------------------------------------------------------------------
package conv_seq_pkg;

    localparam int NUM_WORDS_DEF = 26;
    localparam int TIMEOUT_DEF   = 64;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ARMED      = 4'd1,
        READ       = 4'd2,
        CALC_START = 4'd3,
        CALC_WAIT  = 4'd4,
        STORE      = 4'd5,
        INC        = 4'd6,
        FLUSH      = 4'd7,
        DONE       = 4'd8,
        ERR        = 4'd9
    } state_t;

    // Bits needed to hold 0..v-1, never less than one bit.
    function automatic int clog2w(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/conversion_sequencer_watchdog.sv
// -----------------------------------------------------------------------------
// calc_watchdog
// Counts cycles spent waiting for the calculation unit. The timer is cleared
// when a conversion is launched and advances while waiting without a done.
// o_expired flags that the last allowed wait cycle has been reached; the
// sequencer still gives a same-cycle done priority over expiry.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_clr      clear the timer (conversion launch cycle)
//   i_en       waiting for the calculation unit
//   i_done     calculation unit reports done
//   o_expired  timer has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module calc_watchdog
    import conv_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_done,
    output logic o_expired
);

    localparam int TW = clog2w(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_timer;

    // Saturates at LAST so a stalled FSM can never see the timer wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timer <= '0;
        end else if (i_clr) begin
            r_timer <= '0;
        end else if (i_en && !i_done && (r_timer != LAST)) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign o_expired = (r_timer == LAST);

endmodule

// File: rtl/conversion_sequencer.sv
// -----------------------------------------------------------------------------
// conversion_sequencer
// Steps the number-conversion datapath through a block of NUM_WORDS words:
// read a word, launch the calculation unit, wait for its done (guarded by a
// watchdog), store the result, advance the index, and finally request the file
// write. All outputs are decoded from registered state or are registers.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_start       block start; high then low launches one block
//   i_calc_done   calculation unit finished current word (pulse or level)
//   i_write_ack   file writer accepted the block
//   o_rd_en       one-cycle read strobe to the input buffer
//   o_rd_addr     input buffer word index (= o_count)
//   o_calc_start  one-cycle launch pulse to the calculation unit
//   o_store_en    one-cycle store strobe for the converted number
//   o_wr_addr     result store index (= o_count)
//   o_wr_file     file-write request, held until acknowledged
//   o_busy        high outside IDLE and ARMED
//   o_done        one-cycle pulse at block completion
//   o_err         sticky watchdog error, cleared by the next accepted start
//   o_count       current word index
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for start to go high
// ARMED      | start seen high, waiting for it to drop
// READ       | read strobe for word count
// CALC_START | launch pulse, watchdog cleared
// CALC_WAIT  | waiting for calc_done, watchdog running
// STORE      | store strobe for word count
// INC        | advance index or finish the block
// FLUSH      | file-write request held until write_ack
// DONE       | completion pulse
// ERR        | watchdog expired, set err
// -----------------------------------------------------------------------------
module conversion_sequencer
    import conv_seq_pkg::*;
#(
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_calc_done,
    input  logic             i_write_ack,
    output logic             o_rd_en,
    output logic [CNT_W-1:0] o_rd_addr,
    output logic             o_calc_start,
    output logic             o_store_en,
    output logic [CNT_W-1:0] o_wr_addr,
    output logic             o_wr_file,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             r_err;
    logic             w_expired;

    logic w_rd_en;
    logic w_calc_start;
    logic w_store_en;
    logic w_wr_file;
    logic w_busy;
    logic w_done;

    calc_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (r_state == CALC_START),
        .i_en      (r_state == CALC_WAIT),
        .i_done    (i_calc_done),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = IDLE;
        w_rd_en      = 1'b0;
        w_calc_start = 1'b0;
        w_store_en   = 1'b0;
        w_wr_file    = 1'b0;
        w_done       = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                w_next = i_start ? ARMED : IDLE;
            end
            ARMED: begin
                w_busy = 1'b0;
                w_next = i_start ? ARMED : READ;
            end
            READ: begin
                w_rd_en = 1'b1;
                w_next  = CALC_START;
            end
            CALC_START: begin
                w_calc_start = 1'b1;
                w_next       = CALC_WAIT;
            end
            CALC_WAIT: begin
                // A done on the last allowed cycle beats the watchdog.
                if (i_calc_done) begin
                    w_next = STORE;
                end else if (w_expired) begin
                    w_next = ERR;
                end else begin
                    w_next = CALC_WAIT;
                end
            end
            STORE: begin
                w_store_en = 1'b1;
                w_next     = INC;
            end
            INC: begin
                w_next = (r_count == LAST_IDX) ? FLUSH : READ;
            end
            FLUSH: begin
                w_wr_file = 1'b1;
                w_next    = i_write_ack ? DONE : FLUSH;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            ERR: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Index holds after the block so the host can read the final value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if ((r_state == IDLE) && i_start) begin
            r_count <= '0;
        end else if ((r_state == INC) && (r_count != LAST_IDX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if ((r_state == IDLE) && i_start) begin
            r_err <= 1'b0;
        end else if (r_state == ERR) begin
            r_err <= 1'b1;
        end
    end

    assign o_rd_en      = w_rd_en;
    assign o_rd_addr    = r_count;
    assign o_calc_start = w_calc_start;
    assign o_store_en   = w_store_en;
    assign o_wr_addr    = r_count;
    assign o_wr_file    = w_wr_file;
    assign o_busy       = w_busy;
    assign o_done       = w_done;
    assign o_err        = r_err;
    assign o_count      = r_count;

endmodule

// File: tb/tb_conversion_sequencer.sv
module tb_conversion_sequencer;

    localparam int NUM_WORDS = 26;
    localparam int CNT_W     = 8;
    localparam int TIMEOUT   = 16;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic             i_calc_done = 1'b0;
    logic             i_write_ack = 1'b0;
    logic             o_rd_en;
    logic [CNT_W-1:0] o_rd_addr;
    logic             o_calc_start;
    logic             o_store_en;
    logic [CNT_W-1:0] o_wr_addr;
    logic             o_wr_file;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    logic [CNT_W-1:0] o_count;

    conversion_sequencer #(
        .NUM_WORDS (NUM_WORDS),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_calc_done  (i_calc_done),
        .i_write_ack  (i_write_ack),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .o_calc_start (o_calc_start),
        .o_store_en   (o_store_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_file    (o_wr_file),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_count      (o_count)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    // bookkeeping, cleared per scenario
    int  cyc, n_rd, n_cs, n_store, n_wf, n_done;
    int  exp_rd, exp_wr, last_rd, spacing_bad;
    int  cs_cyc, cs_first, store_first, err_cyc, wf_age;
    int  hang_word, tie_word;
    bit  auto_on, chk_spacing;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_book();
        cyc = 0; n_rd = 0; n_cs = 0; n_store = 0; n_wf = 0; n_done = 0;
        exp_rd = 0; exp_wr = 0; last_rd = -1; spacing_bad = 0;
        cs_cyc = -100; cs_first = -1; store_first = -1; err_cyc = -1; wf_age = 0;
        hang_word = -1; tie_word = -1; chk_spacing = 1'b0;
    endtask

    // One clock: sample outputs just after the edge, then (in auto mode) drive
    // the calculation unit and file writer responses for the next edge.
    task automatic tick();
        int word;
        int d;
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_rd_en) begin
            chk("rd_addr", o_rd_addr, exp_rd);
            if (chk_spacing && last_rd >= 0 && (cyc - last_rd) != 5) spacing_bad++;
            last_rd = cyc;
            exp_rd++;
            n_rd++;
        end
        if (o_calc_start) begin
            cs_cyc = cyc;
            if (cs_first < 0) cs_first = cyc;
            n_cs++;
        end
        if (o_store_en) begin
            chk("wr_addr", o_wr_addr, exp_wr);
            if (store_first < 0) store_first = cyc;
            exp_wr++;
            n_store++;
        end
        if (o_wr_file) n_wf++;
        if (o_done) n_done++;
        if (o_err && err_cyc < 0) err_cyc = cyc;
        if (auto_on) begin
            word = n_cs - 1;
            d = (word == tie_word) ? TIMEOUT : 1;
            i_calc_done = (n_cs > 0) && (word != hang_word) && ((cyc - cs_cyc) == d);
            wf_age = o_wr_file ? wf_age + 1 : 0;
            i_write_ack = (wf_age == 3);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_start = 1'b0;
        i_calc_done = 1'b0;
        i_write_ack = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        clear_book();
    endtask

    task automatic start_block();
        i_start = 1'b1;
        tick();
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_until_end(input string nm, input int budget);
        int k;
        k = 0;
        while (!(o_done || o_err) && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 32'(o_done || o_err), 1);
    endtask

    typedef struct {
        logic       start;
        logic       cd;
        logic       wa;
        logic [6:0] flags;  // {busy, rd_en, calc_start, store_en, wr_file, done, err}
        logic [7:0] cnt;
    } vec_t;

    vec_t vt[11];

    initial begin
        // Inputs applied after an edge; flags expected after the following edge.
        vt[0]  = '{1'b0, 1'b0, 1'b0, 7'b0000000, 8'd0};  // IDLE
        vt[1]  = '{1'b0, 1'b1, 1'b0, 7'b0000000, 8'd0};  // spurious calc_done in IDLE
        vt[2]  = '{1'b0, 1'b0, 1'b1, 7'b0000000, 8'd0};  // spurious write_ack in IDLE
        vt[3]  = '{1'b1, 1'b0, 1'b0, 7'b0000000, 8'd0};  // ARMED
        vt[4]  = '{1'b1, 1'b1, 1'b1, 7'b0000000, 8'd0};  // still ARMED
        vt[5]  = '{1'b0, 1'b0, 1'b0, 7'b1100000, 8'd0};  // READ
        vt[6]  = '{1'b0, 1'b1, 1'b1, 7'b1010000, 8'd0};  // spurious in READ -> CALC_START
        vt[7]  = '{1'b0, 1'b1, 1'b0, 7'b1000000, 8'd0};  // calc_done ignored in CALC_START
        vt[8]  = '{1'b0, 1'b1, 1'b0, 7'b1001000, 8'd0};  // STORE
        vt[9]  = '{1'b0, 1'b0, 1'b0, 7'b1000000, 8'd0};  // INC
        vt[10] = '{1'b0, 1'b0, 1'b0, 7'b1100000, 8'd1};  // READ word 1

        clear_book();
        auto_on = 1'b0;
        #1;
        chk("reset_flags", {25'd0, o_busy, o_rd_en, o_calc_start, o_store_en, o_wr_file, o_done, o_err}, 0);
        chk("reset_count", o_count, 0);
        do_reset();

        // ---- table vectors: IDLE/ARMED/spurious inputs/first word ----
        for (int i = 0; i < 11; i++) begin
            i_start = vt[i].start;
            i_calc_done = vt[i].cd;
            i_write_ack = vt[i].wa;
            tick();
            chk($sformatf("vec%0d_flags", i),
                {25'd0, o_busy, o_rd_en, o_calc_start, o_store_en, o_wr_file, o_done, o_err},
                {25'd0, vt[i].flags});
            chk($sformatf("vec%0d_count", i), o_count, vt[i].cnt);
        end

        // ---- nominal block ----
        auto_on = 1'b1;
        do_reset();
        chk_spacing = 1'b1;
        start_block();
        run_until_end("nominal_finish", 1000);
        chk("nominal_rd", n_rd, NUM_WORDS);
        chk("nominal_store", n_store, NUM_WORDS);
        chk("nominal_spacing_bad", spacing_bad, 0);
        chk("nominal_wr_file_cycles", n_wf, 3);
        chk("nominal_done", n_done, 1);
        chk("nominal_err", o_err, 0);
        chk("nominal_count", o_count, NUM_WORDS - 1);
        tick();
        chk("nominal_idle_busy", o_busy, 0);
        chk("nominal_done_single", n_done, 1);
        chk("nominal_count_hold", o_count, NUM_WORDS - 1);

        // ---- start held high ----
        do_reset();
        begin
            int bad;
            bad = 0;
            i_start = 1'b1;
            repeat (20) begin
                tick();
                if (o_busy || o_rd_en) bad++;
            end
            chk("held_armed_bad", bad, 0);
            i_start = 1'b0;
            tick();
            chk("held_first_rd", o_rd_en, 1);
            chk("held_rd_addr", o_rd_addr, 0);
        end

        // ---- watchdog on word 3 ----
        do_reset();
        hang_word = 3;
        start_block();
        run_until_end("wdog_finish", 1000);
        // TIMEOUT wait cycles, one ERR cycle, then err visible
        chk("wdog_err_latency", err_cyc - cs_cyc, TIMEOUT + 2);
        chk("wdog_err", o_err, 1);
        chk("wdog_store", n_store, 3);
        chk("wdog_busy", o_busy, 0);
        chk("wdog_count", o_count, 3);
        repeat (3) tick();
        chk("wdog_err_sticky", o_err, 1);
        chk("wdog_no_done", n_done, 0);
        chk("wdog_no_more_rd", n_rd, 4);
        i_start = 1'b1;
        tick();
        chk("wdog_err_cleared", o_err, 0);
        chk("wdog_count_cleared", o_count, 0);
        i_start = 1'b0;

        // ---- done on the last watchdog cycle ----
        do_reset();
        tie_word = 0;
        start_block();
        run_until_end("tie_finish", 1000);
        chk("tie_store_latency", store_first - cs_first, TIMEOUT + 1);
        chk("tie_err", o_err, 0);
        chk("tie_done", n_done, 1);
        chk("tie_store", n_store, NUM_WORDS);

        // ---- asynchronous reset mid-block ----
        do_reset();
        hang_word = 10;
        start_block();
        begin
            int k;
            k = 0;
            while (n_cs < 11 && k < 1000) begin
                tick();
                k++;
            end
            chk("midrst_reach_word10", n_cs, 11);
        end
        tick();
        #3;
        i_rst = 1'b1;
        #1;
        chk("midrst_flags", {25'd0, o_busy, o_rd_en, o_calc_start, o_store_en, o_wr_file, o_done, o_err}, 0);
        chk("midrst_count", o_count, 0);
        i_calc_done = 1'b0;
        i_write_ack = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        clear_book();
        start_block();
        run_until_end("midrst_fresh_finish", 1000);
        chk("midrst_fresh_rd", n_rd, NUM_WORDS);
        chk("midrst_fresh_done", n_done, 1);
        chk("midrst_fresh_count", o_count, NUM_WORDS - 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
